// File: rtl/seg7_pkg.sv
// Shared defaults and hex-to-segment table for the multiplexed 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned SEG7_NUM_DIGITS   = 8;
  localparam int unsigned SEG7_SCAN_DIV     = 100000;
  localparam int unsigned SEG7_DEAD         = 16;
  localparam int unsigned SEG7_BRIGHT_W     = 4;
  localparam int unsigned SEG7_BLINK_FRAMES = 64;

  // Active-low segments, bit order g..a (bit0 = a).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_c_o
);

  always_comb begin
    seg_c_o = hex_to_seg(nib_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner with dead-time, PWM brightness, per-digit blink
// and frame-synchronous capture of all display inputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = SEG7_NUM_DIGITS,
  parameter int unsigned SCAN_DIV     = SEG7_SCAN_DIV,
  parameter int unsigned DEAD         = SEG7_DEAD,
  parameter int unsigned BRIGHT_W     = SEG7_BRIGHT_W,
  parameter int unsigned BLINK_FRAMES = SEG7_BLINK_FRAMES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   hexs,
  input  logic [NUM_DIGITS-1:0]     points,
  input  logic [NUM_DIGITS-1:0]     LEs,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic [7:0]                SEGMENT,
  output logic                      frame_done
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  logic [4*NUM_DIGITS-1:0] act_hexs_q;
  logic [NUM_DIGITS-1:0]   act_points_q, act_les_q, act_blink_q;
  logic [BRIGHT_W-1:0]     act_bright_q;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frame_done_q;

  logic                    presc_wrap, digit_wrap, frame_wrap;
  logic [3:0]              cur_nib;
  logic                    cur_point, cur_le, cur_blink, lit;
  logic [6:0]              dec_seg;

  seg7_decode u_decode (
    .nib_i   (cur_nib),
    .seg_c_o (dec_seg)
  );

  // Scan, PWM and blink counter next-state.
  always_comb begin
    presc_wrap    = (presc_q == PRESC_W'(SCAN_DIV - 1));
    digit_wrap    = (digit_q == DIG_W'(NUM_DIGITS - 1));
    frame_wrap    = presc_wrap && digit_wrap;
    presc_d       = presc_wrap ? '0 : presc_q + PRESC_W'(1);
    digit_d       = digit_q;
    pwm_d         = pwm_q + BRIGHT_W'(1);
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (presc_wrap) begin
      digit_d = digit_wrap ? '0 : digit_q + DIG_W'(1);
    end
    if (frame_wrap) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Select the active-frame attributes of the digit being scanned.
  always_comb begin
    cur_nib   = '0;
    cur_point = 1'b0;
    cur_le    = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digit_q == DIG_W'(i)) begin
        cur_nib   = act_hexs_q[4*i +: 4];
        cur_point = act_points_q[i];
        cur_le    = act_les_q[i];
        cur_blink = act_blink_q[i];
      end
    end
  end

  always_comb begin
    lit = (presc_q >= PRESC_W'(DEAD)) && (pwm_q < act_bright_q) && !cur_le &&
          !(cur_blink && blink_phase_q);
    an_d  = '1;
    seg_d = 8'hFF;
    if (lit) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        an_d[i] = (digit_q != DIG_W'(i));
      end
      seg_d = {~cur_point, dec_seg};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q       <= '0;
      digit_q       <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      act_hexs_q    <= '0;
      act_points_q  <= '0;
      act_les_q     <= '0;
      act_blink_q   <= '0;
      act_bright_q  <= '0;
      an_q          <= '1;
      seg_q         <= 8'hFF;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      digit_q       <= digit_d;
      pwm_q         <= pwm_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_done_q  <= frame_wrap;
      // Inputs only enter the display at frame start so a frame never tears.
      if (frame_wrap) begin
        act_hexs_q   <= hexs;
        act_points_q <= points;
        act_les_q    <= LEs;
        act_blink_q  <= blink_mask;
        act_bright_q <= brightness;
      end
    end
  end

  assign AN         = an_q;
  assign SEGMENT    = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL take parameter NUM_DIGITS, default 8: number of multiplexed digits, legal 1..8.
REQ-002 SHALL take parameter SCAN_DIV, default 100000: clk cycles per digit slot, legal >= DEAD+2.
REQ-003 SHALL take parameter DEAD, default 16: anti-ghost blank cycles at slot start, legal >= 0.
REQ-004 SHALL take parameter BRIGHT_W, default 4: width of the brightness PWM.
REQ-005 SHALL take parameter BLINK_FRAMES, default 64: frames per blink half-period, legal >= 1.
REQ-006 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-008 SHALL have port hexs  input  4*NUM_DIGITS: nibble i (hexs[4i+3:4i]) is the digit i value.
REQ-009 SHALL have port points  input  NUM_DIGITS: 1 = light decimal point of digit i.
REQ-010 SHALL have port LEs  input  NUM_DIGITS: 1 = blank digit i entirely.
REQ-011 SHALL have port blink_mask  input  NUM_DIGITS: 1 = digit i blinks.
REQ-012 SHALL have port brightness  input  BRIGHT_W: duty level; 0 = dark.
REQ-013 SHALL have port AN  output  NUM_DIGITS: active-low digit enables.
REQ-014 SHALL have port SEGMENT  output  8: active-low; bit0..6 = a..g, bit7 = p.
REQ-015 SHALL have port frame_done  output  1: one-cycle pulse per completed frame.

Function
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and advance the digit index on wrap.
REQ-017 Digit index SHALL count 0..NUM_DIGITS-1 and wrap to 0; with NUM_DIGITS=1 every slot is a frame.
REQ-018 hexs, points, LEs, blink_mask and brightness SHALL be captured into active registers only on the edge where the digit index wraps to 0; no mid-frame tearing.
REQ-019 frame_done SHALL be 1 for exactly the cycle after that capture edge.
REQ-020 PWM counter (BRIGHT_W bits) SHALL increment every clk, free-running and wrapping.
REQ-021 Current digit SHALL be lit only when: prescaler >= DEAD AND pwm counter < active brightness AND active LEs[i]=0 AND NOT (active blink_mask[i]=1 AND blink phase=1).
REQ-022 When lit, AN SHALL have only bit i low; otherwise AN SHALL be all ones.
REQ-023 SEGMENT[6:0] SHALL be the standard hex 0-F pattern of active nibble i (0 -> 7'b1000000 g..a) when lit, all ones otherwise.
REQ-024 SEGMENT[7] SHALL be 0 only when lit and active points[i]=1.
REQ-025 Blink frame counter SHALL count frames 0..BLINK_FRAMES-1; blink phase SHALL toggle on its wrap.
REQ-026 AN, SEGMENT and frame_done SHALL be registered: they reflect counter/active state one cycle earlier; AN and SEGMENT change on the same edge.
REQ-027 Maximum brightness (all ones) SHALL give duty (2^BRIGHT_W-1)/2^BRIGHT_W of the non-dead part of the slot.
REQ-028 Input changes outside the capture edge SHALL have no effect on outputs until the next frame start.

Reset
REQ-029 rst=0 SHALL immediately force AN all ones, SEGMENT 8'hFF, frame_done 0.
REQ-030 rst=0 SHALL clear prescaler, digit index, PWM counter, blink counter, blink phase and all active registers to 0.
REQ-031 After release, first capture SHALL occur at the first digit-index wrap; display stays dark (brightness 0) until then.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse.

Structure
REQ-033 Shared package seg7_pkg SHALL hold the hex-to-segment table and the parameter defaults.
REQ-034 One sub-module seg7_decode (combinational nibble -> 7 active-low segments) SHALL be instantiated once.

Verification (NUM_DIGITS=4, SCAN_DIV=8, DEAD=1, BRIGHT_W=2, BLINK_FRAMES=2)
REQ-035 hexs=16'h1234, brightness=3, no LEs/blink -> per 8-cycle slot, AN 4'b1111 for 1 cycle then pattern for digits 0..3 in turn at duty 3/4; SEGMENT=digit pattern; frame_done every 32 cycles.
REQ-036 Change hexs from 16'h1234 to 16'hABCD mid-frame -> remaining digits of that frame still show 1234 values; ABCD appears from next frame.
REQ-037 LEs=4'b0100, points=4'b0001 -> digit 2 never lit; digit 0 shows SEGMENT[7]=0 while lit.
REQ-038 blink_mask=4'b1000 -> digit 3 lit in frames 0-1, dark in frames 2-3, lit in 4-5.
REQ-039 brightness=0 -> AN all ones at all times; brightness=1 -> lit 1 of each 4 non-dead cycles.
REQ-040 Assert rst mid-frame -> AN=4'hF, SEGMENT=8'hFF same cycle, no frame_done; after release, first frame_done 32 cycles later.
